// File: rtl/module_tx_uart_pkg.sv
// Shared UART types: TX state encoding and the software-visible data register layout.
package pkg_UART;

    localparam int UART_DATA_BITS = 8;

    typedef struct packed {
        logic [23:0]               zero;
        logic [UART_DATA_BITS-1:0] data;
    } data_UART_r;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_e;

endpackage

// File: rtl/module_tx_uart_baud.sv
// Bit-period counter: tick_o marks the last cycle of each bit; clr_i restarts the period.
module module_baud_tick_uart #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr_i || cnt_q == CNT_MAX) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/module_tx_uart.sv
// UART transmit engine, 8N1 LSB first. Define UART_TX_PARITY_EN to insert an even parity bit.
module module_tx_uart
    import pkg_UART::*;
#(
    parameter int CLK_FREQ_HZ = 10_000_000,
    parameter int BAUD_RATE   = 9_600
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       send_i,
    input  data_UART_r data_i,
    output logic       tx_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;

    if (CLKS_PER_BIT < 2) begin : g_bad_cfg
        $error("module_tx_uart: CLKS_PER_BIT must be >= 2");
    end

    tx_state_e                 state_q, state_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic [2:0]                bit_cnt_q, bit_cnt_d;
    logic                      tx_q, tx_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      accept;
    logic                      tick;
    logic                      unused_zero;

`ifdef UART_TX_PARITY_EN
    logic                      par_q, par_d;
`endif

    assign unused_zero = ^data_i.zero;
    assign accept      = (state_q == TX_IDLE) && send_i;

    module_baud_tick_uart #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (accept),
        .tick_o(tick)
    );

    // tx_d is the line level for the state being entered, so tx_o stays a pure flop output
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d     = par_q;
`endif
        case (state_q)
            TX_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (send_i) begin
                    shift_d   = data_i.data;
                    bit_cnt_d = '0;
                    tx_d      = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = TX_START;
`ifdef UART_TX_PARITY_EN
                    par_d     = ^data_i.data;
`endif
                end
            end
            TX_START: begin
                if (tick) begin
                    tx_d    = shift_q[0];
                    state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tick) begin
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        tx_d    = par_q;
                        state_d = TX_PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = TX_STOP;
`endif
                    end else begin
                        tx_d = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            TX_PARITY: begin
                if (tick) begin
                    tx_d    = 1'b1;
                    state_d = TX_STOP;
                end
            end
`endif
            TX_STOP: begin
                if (tick) begin
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = TX_IDLE;
                end
            end
            default: begin
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = TX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= TX_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    assign tx_o   = tx_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

// File: tb/tb_module_tx_uart.sv
// Self-checking bench for module_tx_uart with a frame-position reference model.
module tb_module_tx_uart;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int SLOTS = 11;
`else
    localparam int SLOTS = 10;
`endif
    localparam int DONE_AT = SLOTS * CPB;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 send = 1'b0;
    pkg_UART::data_UART_r data_w = '0;
    logic                 tx, busy, done;

    int checks   = 0;
    int failures = 0;

    logic rec_tx   [0:99];
    logic rec_busy [0:99];
    logic rec_done [0:99];

    module_tx_uart #(
        .CLK_FREQ_HZ(40),
        .BAUD_RATE  (10)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .send_i(send),
        .data_i(data_w),
        .tx_o  (tx),
        .busy_o(busy),
        .done_o(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame is just a position counter from acceptance; the
    // line level is derived from which bit slot that position falls in.
    int         pos = -1;
    logic [7:0] mbyte = '0;
    bit         en = 1'b0;
    logic       exp_tx = 1'b1, exp_busy = 1'b0, exp_done = 1'b0;

    function automatic logic slot_level(input int p, input logic [7:0] b);
        int s;
        if (p < 0) return 1'b1;
        s = p / CPB;
        if (s == 0) return 1'b0;
        if (s <= 8) return b[s-1];
`ifdef UART_TX_PARITY_EN
        if (s == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        exp_done = 1'b0;
        if (rst) begin
            en  = 1'b1;
            pos = -1;
        end else if (pos < 0) begin
            if (send) begin
                pos   = 0;
                mbyte = data_w.data;
            end
        end else begin
            pos++;
            if (pos == DONE_AT) begin
                pos      = -1;
                exp_done = 1'b1;
            end
        end
        exp_busy = (pos >= 0);
        exp_tx   = slot_level(pos, mbyte);
    end

    always @(posedge clk) begin
        #2;
        if (en) begin
            check("tx_model", int'(tx), int'(exp_tx));
            check("busy_model", int'(busy), int'(exp_busy));
            check("done_model", int'(done), int'(exp_done));
        end
    end

    task automatic rec(input int k);
        @(negedge clk);
        rec_tx[k]   = tx;
        rec_busy[k] = busy;
        rec_done[k] = done;
    endtask

    function automatic int first_done(input int n);
        for (int k = 0; k < n; k++) if (rec_done[k]) return k;
        return -1;
    endfunction

    function automatic int count_done(input int n);
        int c = 0;
        for (int k = 0; k < n; k++) if (rec_done[k]) c++;
        return c;
    endfunction

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    int bits_a5 [0:7] = '{1, 0, 1, 0, 0, 1, 0, 1};
    int bits_5a [0:7] = '{0, 1, 0, 1, 1, 0, 1, 0};

    initial begin
        // 1: reset with send asserted
        send   = 1'b1;
        data_w = 32'h0000_00A5;
        idle(3);
        check("reset_tx", int'(tx), 1);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        rst  = 1'b0;
        send = 1'b0;
        idle(3);
        check("post_reset_busy", int'(busy), 0);

        // 2: 0xA5 frame
        data_w = 32'h0000_00A5;
        send   = 1'b1;
        for (int k = 0; k < 50; k++) begin
            rec(k);
            if (k == 0) send = 1'b0;
        end
        check("a5_busy0", int'(rec_busy[0]), 1);
        check("a5_start", int'(rec_tx[2]), 0);
        for (int i = 0; i < 8; i++) check("a5_bit", int'(rec_tx[4 + 4*i + 2]), bits_a5[i]);
`ifdef UART_TX_PARITY_EN
        check("a5_parity", int'(rec_tx[38]), 0);
        check("a5_done_at", first_done(50), 44);
`else
        check("a5_stop", int'(rec_tx[38]), 1);
        check("a5_done_at", first_done(50), 40);
`endif
        check("a5_done_cnt", count_done(50), 1);
        idle(3);

        // 3: upper word bits ignored
        data_w = 32'hDEAD_BE5A;
        send   = 1'b1;
        for (int k = 0; k < 50; k++) begin
            rec(k);
            if (k == 0) send = 1'b0;
        end
        for (int i = 0; i < 8; i++) check("5a_bit", int'(rec_tx[4 + 4*i + 2]), bits_5a[i]);
        idle(3);

        // 4: send mid-frame is ignored
        data_w = 32'h0000_003C;
        send   = 1'b1;
        for (int k = 0; k < 60; k++) begin
            rec(k);
            if (k == 0) send = 1'b0;
            if (k == 11) begin
                send   = 1'b1;
                data_w = 32'h0;
            end
            if (k == 12) send = 1'b0;
        end
        check("ignore_done_cnt", count_done(60), 1);
        check("ignore_done_at", first_done(60), DONE_AT);
        idle(3);

        // 5: send held high, back-to-back frames
        data_w = 32'h0000_0055;
        send   = 1'b1;
        for (int k = 0; k < 95; k++) begin
            rec(k);
            if (k == 0) data_w = 32'h0000_000F;
            if (k == DONE_AT + 1) send = 1'b0;
        end
        check("b2b_f1_bit0", int'(rec_tx[6]), 1);
        check("b2b_f1_bit1", int'(rec_tx[10]), 0);
        check("b2b_done1", int'(rec_done[DONE_AT]), 1);
        check("b2b_start2", int'(rec_tx[DONE_AT + 1]), 0);
        check("b2b_busy2", int'(rec_busy[DONE_AT + 1]), 1);
        check("b2b_f2_bit0", int'(rec_tx[DONE_AT + 1 + 6]), 1);
        check("b2b_f2_bit4", int'(rec_tx[DONE_AT + 1 + 22]), 0);
        check("b2b_done2", int'(rec_done[2*DONE_AT + 1]), 1);
        check("b2b_done_cnt", count_done(95), 2);
        idle(3);

        // 6: reset mid-frame
        data_w = 32'h0;
        send   = 1'b1;
        for (int k = 0; k < 60; k++) begin
            rec(k);
            if (k == 0) send = 1'b0;
            if (k == 19) rst = 1'b1;
            if (k == 20) rst = 1'b0;
        end
        check("midrst_tx_before", int'(rec_tx[19]), 0);
        check("midrst_tx", int'(rec_tx[20]), 1);
        check("midrst_busy", int'(rec_busy[20]), 0);
        check("midrst_no_done", count_done(60), 0);
        idle(3);

`ifdef UART_TX_PARITY_EN
        // 7: parity of 0x07
        data_w = 32'h0000_0007;
        send   = 1'b1;
        for (int k = 0; k < 50; k++) begin
            rec(k);
            if (k == 0) send = 1'b0;
        end
        check("p07_parity", int'(rec_tx[38]), 1);
        check("p07_stop", int'(rec_tx[42]), 1);
        check("p07_done_at", first_done(50), 44);
        idle(3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
